// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: memory-mapped transmit FIFO in front of tx_uart.
// CPU stores to BASE_ADDR are queued in a DEPTH-entry byte FIFO. A small drain
// state machine hands one byte at a time to tx_uart and waits for its done pulse.
// BASE_ADDR reads back the legacy "store is safe" poll word. BASE_ADDR+4 is
// the status/control register.
module uart_tx_fifo #(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bus_addr,
    input  logic [3:0]  bus_wmask,
    input  logic [31:0] bus_wdata,
    output logic        bus_sel,
    output logic [31:0] bus_rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int              AW         = $clog2(DEPTH);
    localparam int              CW         = AW + 1;
    localparam logic [31:0]     CTRL_ADDR  = BASE_ADDR + 32'd4;
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE    = AW'(1);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t          state_r;
    logic [7:0]      mem_r [DEPTH];
    logic [AW-1:0]   wp_r;
    logic [AW-1:0]   rp_r;
    logic [CW-1:0]   count_r;
    logic            overflow_r;

    logic            full_s;
    logic            empty_s;
    logic            data_hit_s;
    logic            ctrl_hit_s;
    logic            store_s;
    logic            push_s;
    logic            drop_s;
    logic            pop_s;
    logic            ovf_clear_s;
    logic            unused_wdata_s;

    // Only the low byte of the store data carries meaning here.
    assign unused_wdata_s = ^bus_wdata[31:8];

    assign full_s      = (count_r == FULL_COUNT);
    assign empty_s     = (count_r == {CW{1'b0}});
    assign data_hit_s  = (bus_addr == BASE_ADDR);
    assign ctrl_hit_s  = (bus_addr == CTRL_ADDR);
    assign store_s     = (bus_wmask != 4'b0000);
    // Fullness is judged on the registered count, so a pop in the same cycle
    // does not rescue a store made while full.
    assign push_s      = data_hit_s && store_s && !full_s;
    assign drop_s      = data_hit_s && store_s && full_s;
    assign ovf_clear_s = ctrl_hit_s && store_s && bus_wdata[0];
    // The byte leaves the FIFO on the edge that ends the launch cycle.
    assign pop_s       = (state_r == LAUNCH);
    assign bus_sel     = data_hit_s || ctrl_hit_s;

    // Read mux for the two mapped registers; reads have no side effects.
    always_comb begin
        bus_rdata = 32'd0;
        if (data_hit_s) begin
            bus_rdata = full_s ? 32'h0000_0000 : 32'hFFFF_FFFF;
        end else if (ctrl_hit_s) begin
            bus_rdata = {{(24 - CW){1'b0}}, count_r, 5'b00000, overflow_r, full_s, empty_s};
        end else begin
            bus_rdata = 32'd0;
        end
    end

    // Byte storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wp_r] <= bus_wdata[7:0];
        end
    end

    // Pointer and occupancy bookkeeping for push and pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_r    <= {AW{1'b0}};
            rp_r    <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wp_r <= wp_r + PTR_ONE;
            end
            if (pop_s) begin
                rp_r <= rp_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow flag: set by a dropped store, cleared by control write.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (ovf_clear_s) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Drain state machine with registered launch strobe and data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!empty_s) begin
                        state_r  <= LAUNCH;
                        tx_valid <= 1'b1;
                        tx_data  <= mem_r[rp_r];
                    end else begin
                        tx_valid <= 1'b0;
                    end
                end
                LAUNCH: begin
                    state_r  <= WAIT;
                    tx_valid <= 1'b0;
                end
                WAIT: begin
                    tx_valid <= 1'b0;
                    if (tx_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
